// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants, types and address helper for the pixel framebuffer
package pixel_pkg;

    localparam int SCR_W    = 160;
    localparam int SCR_H    = 120;
    localparam int CW       = 3;
    localparam int ADDR_W   = 15;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int FB_DEPTH = SCR_W * SCR_H;

    typedef logic [CW-1:0] colour_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } rd_state_t;

    // y*160 + x as two shifts and adds: y*128 + y*32 + x.
    function automatic logic [ADDR_W-1:0] xy_to_addr(input logic [X_W-1:0] x,
                                                     input logic [Y_W-1:0] y);
        return {1'b0, y, 7'b0} + {3'b0, y, 5'b0} + {7'b0, x};
    endfunction

    function automatic logic xy_in_range(input logic [X_W-1:0] x,
                                         input logic [Y_W-1:0] y);
        return (x < X_W'(SCR_W)) && (y < Y_W'(SCR_H));
    endfunction

endpackage

// File: rtl/fb_ram.sv
// rtl/fb_ram.sv - single-port synchronous framebuffer RAM, write-first, 1-cycle read
// Ports:
//   clk  : clock
//   en   : port enable (read or write this cycle)
//   we   : write enable (valid with en)
//   addr : pixel address
//   din  : write colour
//   dout : read colour, registered; on a write it returns the written colour
module fb_ram
    import pixel_pkg::*;
(
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  colour_t           din,
    output colour_t           dout
);

    // Contents are not touched by reset; power-up value is all zeros.
    colour_t mem [FB_DEPTH] = '{default: '0};

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= din;
                dout      <= din;
            end else begin
                dout      <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/pixel_buffer.sv
// rtl/pixel_buffer.sv - plot-sink framebuffer with request/valid pixel read port
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   vga_x/vga_y/vga_colour: write coordinate and colour
//   vga_plot              : write strobe, one pixel per cycle while high
//   rd_req/rd_x/rd_y      : read request and coordinate, taken when rd_req && rd_ready
//   rd_ready              : high while the read FSM is idle
//   rd_valid/rd_colour    : one-cycle result pulse; colour held until the next pulse
//   oor_err/clr_err       : sticky out-of-range flag and its clear (set wins)
module pixel_buffer
    import pixel_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] vga_x,
    input  logic [Y_W-1:0] vga_y,
    input  colour_t        vga_colour,
    input  logic           vga_plot,
    input  logic           rd_req,
    input  logic [X_W-1:0] rd_x,
    input  logic [Y_W-1:0] rd_y,
    output logic           rd_ready,
    output logic           rd_valid,
    output colour_t        rd_colour,
    output logic           oor_err,
    input  logic           clr_err
);

    rd_state_t         state;
    rd_state_t         state_nxt;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_zero_q;
    logic              wr_in_range;
    logic              rd_in_range;
    logic              wr_en;
    logic              ram_rd;
    logic              accept;
    logic              err_set;
    logic [ADDR_W-1:0] ram_addr;
    colour_t           ram_dout;

    assign wr_in_range = xy_in_range(vga_x, vga_y);
    assign rd_in_range = xy_in_range(rd_x, rd_y);

    // A strobe during reset must not land in the RAM.
    assign wr_en   = vga_plot && wr_in_range && rst_n;
    assign accept  = rd_req && rd_ready;
    assign err_set = (vga_plot && !wr_in_range) || (accept && !rd_in_range);

    // Writes own the single port; the FSM only reads when no strobe is present.
    assign ram_addr = wr_en ? xy_to_addr(vga_x, vga_y) : rd_addr_q;

    fb_ram u_fb_ram (
        .clk  (clk),
        .en   (wr_en || ram_rd),
        .we   (wr_en),
        .addr (ram_addr),
        .din  (vga_colour),
        .dout (ram_dout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    // An out-of-range read skips the RAM and returns colour 0.
                    state_nxt = rd_in_range ? ADDR : DATA;
                end
            end
            ADDR: begin
                if (!vga_plot) begin
                    state_nxt = DATA;
                end
            end
            DATA:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_ready = (state == IDLE);
        ram_rd   = (state == ADDR) && !vga_plot;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_addr_q <= '0;
            rd_zero_q <= 1'b0;
        end else if (accept) begin
            rd_addr_q <= xy_to_addr(rd_x, rd_y);
            rd_zero_q <= !rd_in_range;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid  <= 1'b0;
            rd_colour <= '0;
        end else begin
            rd_valid <= (state == DATA);
            if (state == DATA) begin
                rd_colour <= rd_zero_q ? colour_t'(0) : ram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            oor_err <= 1'b0;
        end else if (err_set) begin
            oor_err <= 1'b1;
        end else if (clr_err) begin
            oor_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pixel_buffer.sv
// tb/tb_pixel_buffer.sv - self-checking bench for pixel_buffer against a pixel-array model
module tb_pixel_buffer;

    localparam int W = 160;
    localparam int H = 120;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;
    logic       rd_req;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_ready;
    logic       rd_valid;
    logic [2:0] rd_colour;
    logic       oor_err;
    logic       clr_err;

    logic [2:0] mem_m [0:W-1][0:H-1];
    bit         exp_oor;
    bit         rd_bad_now;
    int         checks;
    int         failures;

    always #5 clk = ~clk;

    pixel_buffer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_colour  (rd_colour),
        .oor_err    (oor_err),
        .clr_err    (clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Apply the effect of the currently driven inputs to the model, then advance one clock.
    task automatic tick();
        bit err;
        err = rd_bad_now;
        if (!rst_n) begin
            exp_oor = 0;
        end else begin
            if (vga_plot) begin
                if (vga_x < W && vga_y < H) mem_m[vga_x][vga_y] = vga_colour;
                else err = 1;
            end
            if (err) exp_oor = 1;
            else if (clr_err) exp_oor = 0;
        end
        rd_bad_now = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int x, input int y, input int c);
        vga_plot   = 1'b1;
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        tick();
        vga_plot   = 1'b0;
    endtask

    task automatic do_read(input int x, input int y, input int exp_lat, input string tag);
        logic [2:0] expc;
        int         lat;
        bit         bad;
        bad = !(x < W && y < H);
        chk({tag, "_ready"}, 32'(rd_ready), 1);
        rd_req     = 1'b1;
        rd_x       = 8'(x);
        rd_y       = 7'(y);
        rd_bad_now = bad;
        tick();
        rd_req   = 1'b0;
        vga_plot = 1'b0;
        expc = 3'd0;
        if (!bad) expc = mem_m[x][y];
        lat = 0;
        while (lat < 8) begin
            tick();
            lat++;
            if (rd_valid === 1'b1) break;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_colour"}, 32'(rd_colour), 32'(expc));
        if (bad) chk({tag, "_oor"}, 32'(oor_err), 1);
        tick();
        chk({tag, "_pulse_end"}, 32'(rd_valid), 0);
        chk({tag, "_hold"}, 32'(rd_colour), 32'(expc));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int         lat;
        bit         ph;
        bit         seen;
        int         op;
        int         x;
        int         y;

        checks     = 0;
        failures   = 0;
        exp_oor    = 0;
        rd_bad_now = 0;
        for (int i = 0; i < W; i++)
            for (int j = 0; j < H; j++)
                mem_m[i][j] = 3'd0;

        rst_n = 1'b0; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        rd_req = 1'b0; rd_x = '0; rd_y = '0; clr_err = 1'b0;
        repeat (3) tick();
        chk("reset_rd_ready", 32'(rd_ready), 1);
        chk("reset_rd_valid", 32'(rd_valid), 0);
        chk("reset_rd_colour", 32'(rd_colour), 0);
        chk("reset_oor", 32'(oor_err), 0);
        rst_n = 1'b1;
        tick();

        // Basic write then read.
        wr(5, 7, 5);
        tick(); tick();
        do_read(5, 7, 2, "basic");

        // Out-of-range writes are dropped and flagged.
        wr(160, 0, 7);
        chk("oor_x", 32'(oor_err), 32'(exp_oor));
        wr(0, 120, 7);
        chk("oor_y", 32'(oor_err), 32'(exp_oor));
        do_read(0, 0, 2, "oor_unchanged");
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_err", 32'(oor_err), 32'(exp_oor));
        clr_err = 1'b1; wr(200, 3, 7); clr_err = 1'b0;
        chk("clr_vs_set", 32'(oor_err), 32'(exp_oor));
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        do_read(200, 5, 1, "oor_read");
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        chk("clr_after_read", 32'(oor_err), 32'(exp_oor));

        // Read while the writer plots every other cycle.
        chk("stall_ready", 32'(rd_ready), 1);
        rd_req = 1'b1; rd_x = 8'd0; rd_y = 7'd0;
        tick();
        rd_req = 1'b0;
        lat = 0;
        ph  = 1;
        while (lat < 8) begin
            vga_plot = ph;
            if (ph) begin
                vga_x      = 8'(10 + lat);
                vga_y      = 7'd20;
                vga_colour = 3'(lat + 1);
            end
            tick();
            lat++;
            ph = !ph;
            if (rd_valid === 1'b1) break;
        end
        vga_plot = 1'b0;
        chk("stall_latency", 32'(lat), 3);
        chk("stall_colour", 32'(rd_colour), 32'(mem_m[0][0]));
        do_read(10, 20, 2, "stall_wr0");
        do_read(12, 20, 2, "stall_wr2");

        // Write and read request of the same pixel in the same cycle.
        vga_plot = 1'b1; vga_x = 8'd3; vga_y = 7'd3; vga_colour = 3'd2;
        do_read(3, 3, 2, "same_cycle");

        // Reset while the FSM sits in ADDR, with a strobe during reset.
        chk("rst_pre_ready", 32'(rd_ready), 1);
        rd_req = 1'b1; rd_x = 8'd5; rd_y = 7'd7;
        tick();
        rd_req = 1'b0;
        chk("rst_in_addr", 32'(rd_ready), 0);
        rst_n = 1'b0;
        vga_plot = 1'b1; vga_x = 8'd10; vga_y = 7'd10;
        vga_colour = mem_m[10][10] ^ 3'b111;
        tick();
        vga_plot = 1'b0;
        chk("rst_ready", 32'(rd_ready), 1);
        chk("rst_valid", 32'(rd_valid), 0);
        chk("rst_oor", 32'(oor_err), 32'(exp_oor));
        rst_n = 1'b1;
        seen = 0;
        repeat (5) begin
            tick();
            if (rd_valid !== 1'b0) seen = 1;
        end
        chk("rst_no_valid", 32'(seen), 0);
        do_read(10, 10, 2, "rst_no_write");
        do_read(5, 7, 2, "rst_preserve");

        // Randomised traffic against the model.
        for (int n = 0; n < 250; n++) begin
            op = int'($urandom_range(0, 9));
            if (op <= 5) begin
                if ($urandom_range(0, 9) == 0) begin
                    x = int'($urandom_range(0, 255));
                    y = int'($urandom_range(0, 127));
                end else begin
                    x = int'($urandom_range(0, W - 1));
                    y = int'($urandom_range(0, H - 1));
                end
                clr_err = ($urandom_range(0, 3) == 0);
                wr(x, y, int'($urandom_range(0, 7)));
                clr_err = 1'b0;
                repeat ($urandom_range(0, 2)) tick();
            end else if (op <= 8) begin
                do_read(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 2, "rand_read");
            end else begin
                do_read(int'($urandom_range(W, 255)), int'($urandom_range(0, 127)), 1, "rand_oor_read");
            end
            chk("rand_oor", 32'(oor_err), 32'(exp_oor));
        end

        // Full-screen fill at one strobe every two cycles.
        for (int j = 0; j < H; j++) begin
            for (int i = 0; i < W; i++) begin
                wr(i, j, (i + j) % 8);
                tick();
            end
        end
        do_read(0, 0, 2, "corner_00");
        do_read(159, 0, 2, "corner_159_0");
        do_read(0, 119, 2, "corner_0_119");
        do_read(159, 119, 2, "corner_159_119");
        repeat (8) do_read(int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)), 2, "fill_rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pixel_buffer.md
Name: pixel_buffer

Overview:
Plot-sink end of the VGA plot interface: accepts single-pixel write strobes (x, y, colour, plot) from screen-drawing blocks and stores them in a 160x120x3 on-chip framebuffer. Also provides a request/valid read port so game logic can sample the colour at any coordinate, e.g. a snake-head collision check. Sits between the drawing FSMs and game control. Single-port RAM: writes always win; reads wait.

Parameters:
SCR_W, 160, screen width in pixels
SCR_H, 120, screen height in pixels
CW, 3, colour width in bits

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
vga_x  in  8  write x coordinate
vga_y  in  7  write y coordinate
vga_colour  in  CW  write colour
vga_plot  in  1  write strobe; one pixel per cycle while high
rd_req  in  1  read request; accepted when rd_req && rd_ready
rd_x  in  8  read x coordinate, sampled on acceptance
rd_y  in  7  read y coordinate, sampled on acceptance
rd_ready  out  1  high only in IDLE
rd_valid  out  1  one-cycle pulse; rd_colour valid
rd_colour  out  CW  colour read; held until next rd_valid
oor_err  out  1  sticky: an out-of-range write or read occurred
clr_err  in  1  clears oor_err; a new error in the same cycle wins (stays 1)

Behaviour:
- Address = y*SCR_W + x, 15 bits, computed as (y<<7)+(y<<5)+x for the default width. (159,119) -> 19199.
- rst_n does not clear RAM contents; the RAM power-up value is 0.
- Reset values: state IDLE, rd_ready=1, rd_valid=0, rd_colour=0, oor_err=0.
- Write path, independent of the FSM, in every cycle vga_plot=1:
  - If x<SCR_W and y<SCR_H, write colour at the next edge.
  - Otherwise drop the write and set oor_err.
- No backpressure on writes; every in-range strobe is committed.
- FSM states: IDLE, ADDR, DATA.
  - IDLE: rd_ready=1. On rd_req, latch rd_x and rd_y and go to ADDR.
    - If the read coordinate is out of range, go straight to DATA with forced colour 0 and set oor_err.
  - ADDR: rd_ready=0. If vga_plot=1, stall in ADDR because the RAM port is busy. Else issue the RAM read and go to DATA.
  - DATA: capture RAM output into rd_colour, pulse rd_valid=1, return to IDLE.
- Minimum read latency: acceptance edge, then 2 cycles to rd_valid. A back-to-back request can be accepted the cycle after rd_valid.
- A read is starved while vga_plot is held high continuously. Documented limitation; writers must leave idle cycles (fill-style writers plot every other cycle, so a read stalls at most 1 cycle).
- Write then read of the same address: a read issued after the write edge returns the new colour. No stale data; single port, write-first ordering.
- rd_req is ignored outside IDLE; there is no queueing.
- rst_n low mid-read: the FSM returns to IDLE, no rd_valid is issued, and the pending read is discarded. A write strobed in the same cycle as reset is not committed.

Decomposition:
- Shared package pixel_pkg holds:
  - SCR_W, SCR_H, CW
  - ADDR_W=15
  - colour typedef colour_t
  - function xy_to_addr
  - rd_state_t enum {IDLE, ADDR, DATA}
- One sub-module, fb_ram: single-port synchronous RAM, 19200 x CW, write-first, 1-cycle read, initialised to 0. It is the only memory inference point.

Test Plan:
- Write (5,7) colour 3'b101 and idle 2 cycles; read (5,7) -> rd_valid exactly 2 cycles after acceptance, rd_colour=3'b101.
- Write (160,0) and then (0,120) colour 3'b111 -> oor_err=1 and RAM unchanged: read (0,0)=0. Pulse clr_err -> oor_err=0. clr_err together with a new bad write -> oor_err stays 1.
- Read (0,0) while vga_plot toggles high/low every cycle -> FSM stalls in ADDR on each high cycle. rd_valid arrives within 3 cycles of acceptance and no write is lost: verify via readback.
- Fill all 19200 pixels with colour (x+y)%8, one strobe every 2 cycles; read corners (0,0)=0, (159,0)=7, (0,119)=7, (159,119)=6.
- Assert rst_n low in ADDR state -> next cycle rd_ready=1 and rd_valid=0; no rd_valid ever issues for that request. RAM contents are preserved.
- Write (3,3) colour 2 at cycle N; rd_req for (3,3) at cycle N -> rd_colour=2.
